// File: rtl/codec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codec_pkg
// Description : Shared types and timing constants for the CS4272 controller.
// Revision    : 1.0 - initial release
// ============================================================================
package codec_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int               CNT_W     = 10;
    localparam int               WORD_W    = 16;
    localparam logic [4:0]       SAMPLE_PH = 5'd15;
    localparam logic [4:0]       SHIFT_PH  = 5'd0;
    localparam logic [CNT_W-1:0] VALID_CNT = 10'd1008;
    localparam logic [CNT_W-1:0] LATCH_CNT = 10'd1023;

endpackage
`default_nettype wire

// File: rtl/codec_timebase.sv
`default_nettype none
// ============================================================================
// Module      : codec_timebase
// Description : Free-running frame counter with registered MCLK/SCLK/LRCLK.
// Revision    : 1.0 - initial release
// ============================================================================
module codec_timebase
    import codec_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             mclk_o,
    output logic             sclk_o,
    output logic             lrclk_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             mclk_q;
    logic             sclk_q;
    logic             lrclk_q;

    assign cnt_d = cnt_q + CNT_W'(1);

    // Clocks are taken from the next count so they line up with cnt_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            mclk_q  <= 1'b0;
            sclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mclk_q  <= cnt_d[1];
            sclk_q  <= cnt_d[4];
            lrclk_q <= cnt_d[CNT_W-1];
        end
    end

    assign cnt_o   = cnt_q;
    assign wrap_o  = (cnt_q == LATCH_CNT);
    assign mclk_o  = mclk_q;
    assign sclk_o  = sclk_q;
    assign lrclk_o = lrclk_q;

endmodule
`default_nettype wire

// File: rtl/codec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : codec_ctrl
// Description : CS4272 slave-mode controller: reset sequencing, ADC capture,
//               DAC serialisation. Define CODEC_LOOPBACK_EN to feed captured
//               ADC samples back to the DAC instead of lft_in/rht_in.
// Revision    : 1.0 - initial release
// ============================================================================
module codec_ctrl
    import codec_pkg::*;
#(
    parameter int HOLD_FRAMES = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    output logic              MCLK,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              RSTn,
    input  logic              SDout,
    output logic              SDin,
    input  logic [WORD_W-1:0] lft_in,
    input  logic [WORD_W-1:0] rht_in,
    output logic [WORD_W-1:0] lft_out,
    output logic [WORD_W-1:0] rht_out,
    output logic              valid
);

    localparam int              FR_W       = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [FR_W-1:0] LAST_FRAME = FR_W'(HOLD_FRAMES - 1);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic              wrap;

    state_e            state_q,  state_d;
    logic [FR_W-1:0]   frames_q, frames_d;
    logic              rstn_q,   rstn_d;
    logic [WORD_W-1:0] rsr_q,    rsr_d;
    logic [WORD_W-1:0] lsr_q,    lsr_d;
    logic [WORD_W-1:0] lout_q,   lout_d;
    logic [WORD_W-1:0] rout_q,   rout_d;
    logic              valid_q,  valid_d;
    logic [WORD_W-1:0] txl_q,    txl_d;
    logic [WORD_W-1:0] txr_q,    txr_d;
    logic              sdin_q,   sdin_d;

    codec_timebase u_timebase (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_o   (cnt),
        .wrap_o  (wrap),
        .mclk_o  (MCLK),
        .sclk_o  (SCLK),
        .lrclk_o (LRCLK)
    );

    assign cnt_nx = cnt + CNT_W'(1);

`ifdef CODEC_LOOPBACK_EN
    logic unused_dac_in;
    assign unused_dac_in = ^{lft_in, rht_in};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HOLD;
            frames_q <= '0;
            rstn_q   <= 1'b0;
            rsr_q    <= '0;
            lsr_q    <= '0;
            lout_q   <= '0;
            rout_q   <= '0;
            valid_q  <= 1'b0;
            txl_q    <= '0;
            txr_q    <= '0;
            sdin_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            frames_q <= frames_d;
            rstn_q   <= rstn_d;
            rsr_q    <= rsr_d;
            lsr_q    <= lsr_d;
            lout_q   <= lout_d;
            rout_q   <= rout_d;
            valid_q  <= valid_d;
            txl_q    <= txl_d;
            txr_q    <= txr_d;
            sdin_q   <= sdin_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        frames_d = frames_q;
        rstn_d   = rstn_q;
        rsr_d    = rsr_q;
        lsr_d    = lsr_q;
        lout_d   = lout_q;
        rout_d   = rout_q;
        valid_d  = 1'b0;
        txl_d    = txl_q;
        txr_d    = txr_q;
        sdin_d   = sdin_q;

        // Codec reset releases on the wrap edge, i.e. on an LRCLK falling edge.
        case (state_q)
            HOLD: begin
                if (wrap) begin
                    if (frames_q == LAST_FRAME) begin
                        state_d = SYNC;
                        rstn_d  = 1'b1;
                    end else begin
                        frames_d = frames_q + 1'b1;
                    end
                end
            end
            SYNC: begin
                if (cnt_nx == VALID_CNT) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        if (cnt[4:0] == SAMPLE_PH) begin
            if (cnt[CNT_W-1]) begin
                lsr_d = {lsr_q[WORD_W-2:0], SDout};
            end else begin
                rsr_d = {rsr_q[WORD_W-2:0], SDout};
            end
        end

        // Registered on the edge entering VALID_CNT so the last left bit is included.
        if ((state_q != HOLD) && (cnt_nx == VALID_CNT)) begin
            lout_d  = lsr_d;
            rout_d  = rsr_q;
            valid_d = (state_q == RUN);
        end

        if (wrap) begin
`ifdef CODEC_LOOPBACK_EN
            txl_d = lout_q;
            txr_d = rout_q;
`else
            txl_d = lft_in;
            txr_d = rht_in;
`endif
        end

        // Drive the bit for the upcoming SCLK period; uses freshly latched buffers at the wrap.
        if (cnt_nx[4:0] == SHIFT_PH) begin
            if (state_d == HOLD) begin
                sdin_d = 1'b0;
            end else if (cnt_nx[CNT_W-1]) begin
                sdin_d = txl_d[~cnt_nx[8:5]];
            end else begin
                sdin_d = txr_d[~cnt_nx[8:5]];
            end
        end
    end

    assign RSTn    = rstn_q;
    assign SDin    = sdin_q;
    assign lft_out = lout_q;
    assign rht_out = rout_q;
    assign valid   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_codec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_codec_ctrl
// Description : Directed self-checking bench for codec_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_codec_ctrl;

    localparam int HOLD_FRAMES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MCLK, SCLK, LRCLK, RSTn, SDin, valid;
    logic        SDout;
    logic [15:0] lft_in, rht_in, lft_out, rht_out;

    logic [9:0]  tb_cnt;
    logic [15:0] adc_l, adc_r;
    logic [15:0] fr_l, fr_r;
    logic [15:0] mdl_l, mdl_r;
    logic [15:0] tx_l, tx_r;
    int          edge_n;
    int          checks;
    int          errors;

    codec_ctrl #(.HOLD_FRAMES(HOLD_FRAMES)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .MCLK    (MCLK),
        .SCLK    (SCLK),
        .LRCLK   (LRCLK),
        .RSTn    (RSTn),
        .SDout   (SDout),
        .SDin    (SDin),
        .lft_in  (lft_in),
        .rht_in  (rht_in),
        .lft_out (lft_out),
        .rht_out (rht_out),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    // Reference frame position and left-justified ADC serializer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 10'd0;
        else        tb_cnt <= tb_cnt + 10'd1;
    end

    assign SDout = tb_cnt[9] ? adc_l[~tb_cnt[8:5]] : adc_r[~tb_cnt[8:5]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic step_chk();
        logic       hold;
        logic [3:0] b;
        logic       exp_sd;
        @(posedge clk);
        #1;
        edge_n++;
        hold = (edge_n < HOLD_FRAMES * 1024);
        if (tb_cnt == 10'd0) begin
`ifdef CODEC_LOOPBACK_EN
            tx_l = mdl_l;
            tx_r = mdl_r;
`else
            tx_l = lft_in;
            tx_r = rht_in;
`endif
        end
        if (tb_cnt == 10'd1) begin
            fr_l = adc_l;
            fr_r = adc_r;
        end
        if (!hold && tb_cnt == 10'd1008) begin
            mdl_l = fr_l;
            mdl_r = fr_r;
        end
        b      = tb_cnt[8:5];
        exp_sd = hold ? 1'b0 : (tb_cnt[9] ? tx_l[~b] : tx_r[~b]);
        chk("mclk",  {31'd0, MCLK},  {31'd0, tb_cnt[1]});
        chk("sclk",  {31'd0, SCLK},  {31'd0, tb_cnt[4]});
        chk("lrclk", {31'd0, LRCLK}, {31'd0, tb_cnt[9]});
        chk("rstn",  {31'd0, RSTn},  {31'd0, !hold});
        chk("sdin",  {31'd0, SDin},  {31'd0, exp_sd});
        chk("valid", {31'd0, valid},
            {31'd0, (edge_n >= (HOLD_FRAMES + 1) * 1024) && (tb_cnt == 10'd1008)});
        if (!hold && tb_cnt == 10'd1008) begin
            chk("lft_out", {16'd0, lft_out}, {16'd0, mdl_l});
            chk("rht_out", {16'd0, rht_out}, {16'd0, mdl_r});
        end
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) step_chk();
    endtask

    task automatic model_reset();
        edge_n = 0;
        mdl_l  = '0;
        mdl_r  = '0;
        tx_l   = '0;
        tx_r   = '0;
        fr_l   = adc_l;
        fr_r   = adc_r;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        adc_r  = 16'hA5C3;
        adc_l  = 16'h0F0F;
        rht_in = 16'h7FFE;
        lft_in = 16'h8001;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {22'd0, MCLK, SCLK, LRCLK, RSTn, SDin, valid, 4'd0}, 32'd0);
        chk("reset_lft", {16'd0, lft_out}, 32'd0);
        chk("reset_rht", {16'd0, rht_out}, 32'd0);
        rst_n = 1'b1;

        // HOLD, SYNC and first RUN frame with A5C3/0F0F
        run_to(4096);
        // Second ADC pattern, and a DAC change mid-frame
        adc_r = 16'h8000;
        adc_l = 16'h7FFF;
        run_to(4196);
        rht_in = 16'h1234;
        lft_in = 16'hFEDC;
        run_to(5120);
        // Third ADC pattern; loopback builds echo it on SDin next frame
        adc_l = 16'h2468;
        adc_r = 16'h1357;
        run_to(7168 + 700);

        // Asynchronous reset at cnt=700 in RUN
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {22'd0, MCLK, SCLK, LRCLK, RSTn, SDin, valid, 4'd0}, 32'd0);
        chk("midrst_lft", {16'd0, lft_out}, 32'd0);
        chk("midrst_rht", {16'd0, rht_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        run_to((HOLD_FRAMES + 1) * 1024 + 1008 + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
